// File: rtl/bcd_display_scan_if.sv
// Converter-side bus of the multiplexed 7-segment scanner: BCD word and strobes in, display pins out.
interface bcd_display_scan_if #(
    parameter int NIBBLES = 10
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [NIBBLES*4-1:0] bcd;
    logic                 load;
    logic                 blank_lz;
    logic [6:0]           seg;
    logic [NIBBLES-1:0]   an;
    logic [IW-1:0]        scan_idx;
    logic                 busy_tick;

    modport master (
        output bcd, load, blank_lz,
        input  seg, an, scan_idx, busy_tick
    );

    modport slave (
        input  bcd, load, blank_lz,
        output seg, an, scan_idx, busy_tick
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Captures a packed BCD word and time-multiplexes it onto a 7-segment display,
// one digit per SCAN_DIV cycles, with leading-zero blanking and dashes for invalid nibbles.
module bcd_display_scan #(
    parameter int NIBBLES        = 10,
    parameter int SCAN_DIV       = 100000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    bcd_display_scan_if.slave bus
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic POL = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0]         SEG_OFF = {7{POL}};
    localparam logic [NIBBLES-1:0] AN_OFF  = {NIBBLES{POL}};

    logic [NIBBLES*4-1:0] r_cap;
    logic [PW-1:0]        r_pre;
    logic [IW-1:0]        r_idx;
    logic                 r_tick;
    logic [6:0]           r_seg;
    logic [NIBBLES-1:0]   r_an;

    logic                 w_tc;
    logic [IW-1:0]        w_idx_nxt;
    logic [NIBBLES-1:0]   w_hi_zero;
    logic [3:0]           w_nib;
    logic                 w_hz;
    logic                 w_blank;
    logic [6:0]           w_dec;
    logic [NIBBLES-1:0]   w_onehot;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'd0:    f_decode = 7'b0111111;
            4'd1:    f_decode = 7'b0000110;
            4'd2:    f_decode = 7'b1011011;
            4'd3:    f_decode = 7'b1001111;
            4'd4:    f_decode = 7'b1100110;
            4'd5:    f_decode = 7'b1101101;
            4'd6:    f_decode = 7'b1111101;
            4'd7:    f_decode = 7'b0000111;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1101111;
            default: f_decode = 7'b1000000;
        endcase
    endfunction

    assign w_tc      = (r_pre == PW'(SCAN_DIV - 1));
    assign w_idx_nxt = (r_idx == IW'(NIBBLES - 1)) ? '0 : r_idx + 1'b1;

    // w_hi_zero[k]: nibbles k..NIBBLES-1 are all zero (invalid codes are non-zero by construction)
    genvar k;
    generate
        for (k = 0; k < NIBBLES; k++) begin : g_hz
            assign w_hi_zero[k] = (r_cap[NIBBLES*4-1:4*k] == '0);
        end
    endgenerate

    always_comb begin
        w_nib = 4'd0;
        w_hz  = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib = r_cap[4*i +: 4];
                w_hz  = w_hi_zero[i];
            end
        end
    end

    assign w_blank  = bus.blank_lz && (r_idx != '0) && w_hz;
    assign w_dec    = f_decode(w_nib);
    assign w_onehot = NIBBLES'(1) << r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap  <= '0;
            r_pre  <= '0;
            r_idx  <= '0;
            r_tick <= 1'b0;
            r_seg  <= SEG_OFF;
            r_an   <= AN_OFF;
        end else begin
            if (bus.load)
                r_cap <= bus.bcd;
            r_pre  <= w_tc ? '0 : r_pre + 1'b1;
            r_tick <= w_tc;
            if (w_tc)
                r_idx <= w_idx_nxt;
            // Output stage looks at the pre-edge state, giving one cycle of latency
            r_seg <= w_blank ? SEG_OFF : (w_dec ^ SEG_OFF);
            r_an  <= w_blank ? AN_OFF  : (w_onehot ^ AN_OFF);
        end
    end

    assign bus.seg       = r_seg;
    assign bus.an        = r_an;
    assign bus.scan_idx  = r_idx;
    assign bus.busy_tick = r_tick;
endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized bench for bcd_display_scan against a cycle-count reference model.
module tb_bcd_display_scan;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int AL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_display_scan_if #(.NIBBLES(N)) bus ();

    bcd_display_scan #(.NIBBLES(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(AL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tot = 0;
    int n_bad = 0;

    // Active-high g..a glyphs indexed by nibble value
    logic [6:0] PAT [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                             7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

    // Model: m_e = clock edges since the last reset edge; the digit index is just m_e/SD mod N
    logic [4*N-1:0] m_cap;
    int             m_e;
    logic [6:0]     e_seg;
    logic [N-1:0]   e_an;
    int             e_idx;
    logic           e_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        n_tot++;
        n_bad++;
        $display("FAIL %s: wait bound expired", tag);
    endtask

    task automatic cyc();
        int         d;
        logic [3:0] nib;
        logic       blank;
        logic [6:0] s;
        logic [N-1:0] a;
        @(posedge clk);
        if (rst) begin
            e_seg  = AL ? 7'h7F : 7'h00;
            e_an   = AL ? '1 : '0;
            e_idx  = 0;
            e_tick = 1'b0;
            m_cap  = '0;
            m_e    = 0;
        end else begin
            d     = (m_e / SD) % N;
            nib   = 4'(m_cap >> (4 * d));
            blank = bus.blank_lz && (d > 0) && ((m_cap >> (4 * d)) == 0);
            s     = blank ? 7'h00 : PAT[nib];
            a     = blank ? '0 : (N'(1) << d);
            e_seg = AL ? ~s : s;
            e_an  = AL ? ~a : a;
            m_e++;
            e_idx  = (m_e / SD) % N;
            e_tick = (m_e % SD) == 0;
            if (bus.load) m_cap = bus.bcd;
        end
        @(negedge clk);
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("an", 32'(bus.an), 32'(e_an));
        chk("scan_idx", 32'(bus.scan_idx), 32'(e_idx));
        chk("busy_tick", 32'(bus.busy_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic logic [4*N-1:0] rand_bcd();
        logic [4*N-1:0] v;
        int r;
        v = '0;
        for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       v[4*i +: 4] = 4'd0;
            else if (r == 9) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else             v[4*i +: 4] = 4'($urandom_range(1, 9));
        end
        return v;
    endfunction

    initial begin
        int budget;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.bcd = '0;
        bus.blank_lz = 1'b0;
        m_cap = '0;
        m_e = 0;
        run(3);
        chk("rst_seg_lit", 32'(bus.seg), 32'h7F);
        chk("rst_an_lit", 32'(bus.an), 32'hF);
        rst = 1'b0;
        cyc();
        chk("first_seg_lit", 32'(bus.seg), 32'b1000000);
        chk("first_an_lit", 32'(bus.an), 32'b1110);

        // Scan order and period
        bus.bcd = 16'h1234; bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        run(34);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        bus.bcd = 16'h0042; bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (e_an == 4'b1110) chk("lz_digit0_lit", 32'(bus.seg), 32'b0100100);
        end
        bus.bcd = 16'h0000; bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        run(18);

        // Invalid nibble
        bus.bcd = 16'h00A5; bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (e_an == 4'b1101) chk("dash_lit", 32'(bus.seg), 32'b0111111);
        end

        // Load coinciding with the prescaler terminal count
        bus.blank_lz = 1'b0;
        budget = 0;
        while ((m_e % SD) != SD - 1 && budget < 16) begin cyc(); budget++; end
        if ((m_e % SD) != SD - 1) timeout("sim_load_align");
        bus.bcd = 16'h9999; bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        run(10);

        // Reset while scan_idx=2 and prescaler=1
        budget = 0;
        while (!(((m_e / SD) % N) == 2 && (m_e % SD) == 1) && budget < 64) begin cyc(); budget++; end
        if (!(((m_e / SD) % N) == 2 && (m_e % SD) == 1)) timeout("midrst_align");
        rst = 1'b1;
        cyc();
        chk("midrst_seg_lit", 32'(bus.seg), 32'h7F);
        chk("midrst_idx_lit", 32'(bus.scan_idx), 32'd0);
        rst = 1'b0;
        cyc();
        chk("midrst_zero_lit", 32'(bus.seg), 32'b1000000);
        run(10);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.load = ($urandom_range(0, 7) == 0);
            bus.bcd = rand_bcd();
            if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the combinational binary-to-BCD converter's packed BCD output.
- Captures a BCD word on a load strobe and drives a common-anode or common-cathode multiplexed 7-segment display.
- Scans one digit per scan period, with optional leading-zero blanking and a dash for invalid nibbles.
- Sits between the converter and the board display pins.

Parameters:
- NIBBLES, 10, number of BCD digits. Matches the converter width for a 32-bit input.
- SCAN_DIV, 100000, clock cycles per digit slot. Must be >= 1.
- SEG_ACTIVE_LOW, 1, 1 = seg and an are driven active-low, 0 = active-high.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bcd  input  NIBBLES*4  packed BCD from the converter. Nibble k = bcd[4k+:4]; k=0 is the least significant digit.
- load  input  1  capture bcd into the display register this cycle
- blank_lz  input  1  enable leading-zero blanking. Sampled every cycle, not captured.
- seg  output  7  segments, seg[0]=a … seg[6]=g, registered
- an  output  NIBBLES  one-hot digit enable, an[k] = digit k, registered
- scan_idx  output  $clog2(NIBBLES) (min 1)  digit index currently being driven, registered
- busy_tick  output  1  one-cycle pulse on the cycle scan_idx advances

Behaviour:
- Reset (rst=1 at a clock edge) clears: capture register = 0, prescaler = 0, scan_idx = 0, busy_tick = 0, every segment and every an bit inactive (1 when SEG_ACTIVE_LOW=1). Reset has priority over load and over the scan tick.
- Capture: load=1 at an edge puts bcd in the capture register that edge. Load does not touch the prescaler or scan_idx.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. At terminal count SCAN_DIV-1, the scan tick asserts internally for that cycle.
  - The next edge advances the index: scan_idx+1, or 0 after NIBBLES-1. busy_tick is registered high for exactly one cycle alongside the new index.
  - SCAN_DIV=1 advances every cycle.
- Output stage: registered, one cycle of latency from state. seg and an at edge n+1 reflect capture register, scan_idx and blank_lz as they stood after edge n.
  - First post-reset output cycle shows digit 0 = "0".
  - load at edge n is visible on seg at edge n+1 if the digit being driven changed.
- Decode (active-high form, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Nibbles 10..15 show dash = 1000000.
  - Final output is inverted when SEG_ACTIVE_LOW=1.
- Blanking: digit k (k>0) is blank when blank_lz=1 and every nibble k..NIBBLES-1 of the capture register is 0.
  - Digit 0 is never blank.
  - An invalid nibble counts as non-zero.
  - A blank digit drives that an bit and all seg inactive, but still occupies its scan slot; the duty cycle of the other digits is unchanged.
- an: exactly one bit active outside reset and outside blanked slots; never more than one active.
- load and the scan tick in the same cycle: both take effect. The capture update and index advance happen on the same edge, and the next output cycle uses the new value and new index.
- Reset mid-scan: state returns to the reset values on that edge. Scanning restarts from digit 0 with a full SCAN_DIV period.

Test Plan:
- Reset behaviour (NIBBLES=4, SCAN_DIV=4, SEG_ACTIVE_LOW=1): hold rst 3 cycles → seg=7'h7F, an=4'hF, scan_idx=0, busy_tick=0. Release → next cycle seg=7'b1000000 ("0"), an=4'b1110.
- Scan timing (same config): load bcd=16'h1234, blank_lz=0 → digits in order 4,3,2,1, each held exactly 4 cycles. busy_tick pulses every 4 cycles; scan_idx wraps 3→0.
- Blanking: load 16'h0042 with blank_lz=1 → digit0 shows "2" (seg=7'b0100100), digit1 shows "4". In slots 2 and 3, an=4'hF and seg=7'h7F. Load 16'h0000 → only digit 0 lit, showing "0".
- Invalid nibble: load 16'h00A5, blank_lz=1 → digit1 shows dash (seg=7'b0111111), digit0 shows "5". Digits 2 and 3 are blank.
- Simultaneous events: assert load=1 (bcd=16'h9999) on the exact cycle the prescaler is at 3 → the next output cycle shows "9" on the next digit, with no lost or duplicated slot.
- Reset mid-operation: assert rst while scan_idx=2 and prescaler=1 → next cycle matches the reset state. The capture register reads 0 and digit 0 "0" is displayed after release.
